// File: rtl/mem_store_unit.sv
// mem_store_unit: M-stage store formatter and single-transaction SRAM-like
// write master. Builds lane-replicated write data and byte strobes for
// SB/SH/SW, flags misaligned stores (AdES), stalls the pipeline until the
// bus acknowledges the write, and gives up after TIMEOUT cycles in WAIT.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; a store may be accepted this cycle
// REQ   | data_req_o high, fields frozen until the bus takes the address
// WAIT  | address taken, waiting for data_ok; cnt counts up to TIMEOUT-1
module mem_store_unit #(
  parameter int         TIMEOUT = 64,
  parameter logic [5:0] OP_SB   = 6'h28,
  parameter logic [5:0] OP_SH   = 6'h29,
  parameter logic [5:0] OP_SW   = 6'h2B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_i,
  input  logic        store_valid_i,
  input  logic [31:0] aluout_i,
  input  logic [31:0] writedata_i,
  input  logic        flush_i,
  input  logic        adv_i,
  output logic        stall_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        done_o,
  output logic        bus_err_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_wstrb_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic [1:0]    size_q, size_d;

  logic          is_sb, is_sh, is_sw, is_store;
  logic          ades;
  logic          acc;
  logic [31:0]   fmt_wdata;
  logic [3:0]    fmt_strb;
  logic [1:0]    fmt_size;
  logic          done, bus_err, req, timeout;

  // Decode the op, format lane data/strobes and detect misalignment.
  always_comb begin
    is_sb     = (op_i == OP_SB);
    is_sh     = (op_i == OP_SH);
    is_sw     = (op_i == OP_SW);
    is_store  = is_sb | is_sh | is_sw;
    fmt_wdata = writedata_i;
    fmt_strb  = 4'b1111;
    fmt_size  = 2'd2;
    if (is_sb) begin
      fmt_wdata = {4{writedata_i[7:0]}};
      fmt_strb  = 4'b0001 << aluout_i[1:0];
      fmt_size  = 2'd0;
    end else if (is_sh) begin
      fmt_wdata = {2{writedata_i[15:0]}};
      fmt_strb  = aluout_i[1] ? 4'b1100 : 4'b0011;
      fmt_size  = 2'd1;
    end
    ades = store_valid_i &
           ((is_sh & aluout_i[0]) | (is_sw & (aluout_i[1:0] != 2'b00)));
    // hold keeps a store that is still sitting in M from being issued twice
    acc  = (state_q == IDLE) & store_valid_i & is_store & ~ades &
           ~flush_i & ~hold_q;
  end

  // Next-state, transaction bookkeeping and per-cycle handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    size_d  = size_q;
    done    = 1'b0;
    bus_err = 1'b0;
    req     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = aluout_i;
          wdata_d = fmt_wdata;
          strb_d  = fmt_strb;
          size_d  = fmt_size;
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (data_addr_ok_i) begin
          if (data_data_ok_i) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // data_ok wins over a timeout landing in the same cycle
        if (data_data_ok_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          bus_err = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv_i) begin
      hold_d = 1'b0;
    end else if (done | bus_err) begin
      hold_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  // State, counter, hold flag and latched transaction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      size_q  <= size_d;
    end
  end

  // Output drive: bus fields come straight from the latched registers.
  always_comb begin
    stall_o      = acc | (state_q == REQ) |
                   ((state_q == WAIT) & ~data_data_ok_i & ~timeout);
    ades_o       = ades;
    badvaddr_o   = ades ? aluout_i : 32'h0;
    done_o       = done;
    bus_err_o    = bus_err;
    data_req_o   = req;
    data_wr_o    = req;
    data_size_o  = size_q;
    data_addr_o  = addr_q;
    data_wdata_o = wdata_q;
    data_wstrb_o = strb_q;
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit (TIMEOUT=4). Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_store_unit;

  localparam logic [5:0] SB = 6'h28;
  localparam logic [5:0] SH = 6'h29;
  localparam logic [5:0] SW = 6'h2B;
  localparam logic [5:0] LW = 6'h23;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        valid, flush, adv, addr_ok, data_ok;
  logic [31:0] alu, wd;
  logic        stall, ades, done, berr, req, wr;
  logic [31:0] badv, daddr, dwdata;
  logic [1:0]  dsize;
  logic [3:0]  dstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .op_i           (op),
    .store_valid_i  (valid),
    .aluout_i       (alu),
    .writedata_i    (wd),
    .flush_i        (flush),
    .adv_i          (adv),
    .stall_o        (stall),
    .ades_o         (ades),
    .badvaddr_o     (badv),
    .done_o         (done),
    .bus_err_o      (berr),
    .data_req_o     (req),
    .data_wr_o      (wr),
    .data_size_o    (dsize),
    .data_addr_o    (daddr),
    .data_wdata_o   (dwdata),
    .data_wstrb_o   (dstrb),
    .data_addr_ok_i (addr_ok),
    .data_data_ok_i (data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op = '0; valid = 1'b0; flush = 1'b0; adv = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; alu = '0; wd = '0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_stall", stall, 0);  chk("rst_req", req, 0);
    chk("rst_done", done, 0);    chk("rst_berr", berr, 0);
    chk("rst_wdata", dwdata, 0); chk("rst_strb", dstrb, 0);
    chk("rst_addr", daddr, 0);   chk("rst_size", dsize, 0);

    // SB to byte lane 3, addr_ok then data_ok a cycle later
    tick(); valid = 1; op = SB; alu = 32'h1003; wd = 32'h0000_00AB; #1;
    chk("sb_acc_stall", stall, 1); chk("sb_ades", ades, 0);
    chk("sb_badv", badv, 0);       chk("sb_acc_req", req, 0);
    tick(); addr_ok = 1; #1;
    chk("sb_req", req, 1);   chk("sb_wr", wr, 1);
    chk("sb_wdata", dwdata, 32'hABAB_ABAB);
    chk("sb_strb", dstrb, 4'b1000); chk("sb_size", dsize, 0);
    chk("sb_addr", daddr, 32'h1003); chk("sb_req_stall", stall, 1);
    tick(); addr_ok = 0; data_ok = 1; #1;
    chk("sb_wait_req", req, 0); chk("sb_done", done, 1); chk("sb_dok_stall", stall, 0);
    tick(); data_ok = 0; valid = 0; adv = 1; #1;
    chk("sb_done_pulse", done, 0); chk("sb_idle_stall", stall, 0);

    // SH upper half, addr_ok+data_ok together, then held by hold
    tick(); adv = 0; valid = 1; op = SH; alu = 32'h2002; wd = 32'h0000_1234; #1;
    chk("sh_acc_stall", stall, 1);
    tick(); addr_ok = 1; data_ok = 1; #1;
    chk("sh_req", req, 1); chk("sh_strb", dstrb, 4'b1100);
    chk("sh_wdata", dwdata, 32'h1234_1234); chk("sh_size", dsize, 1);
    chk("sh_fast_done", done, 1);
    tick(); addr_ok = 0; data_ok = 0; #1;
    chk("sh_idle_done", done, 0); chk("hold_stall", stall, 0); chk("hold_req0", req, 0);
    tick(); #1;
    chk("hold_req1", req, 0); chk("hold_stall1", stall, 0);
    tick(); adv = 1; #1;
    chk("hold_adv_stall", stall, 0);
    tick(); adv = 0; #1;
    chk("readv_acc_stall", stall, 1);
    tick(); addr_ok = 1; data_ok = 1; #1;
    chk("readv_req", req, 1); chk("readv_done", done, 1);
    tick(); addr_ok = 0; data_ok = 0; valid = 0; adv = 1;

    // misaligned stores and a non-store op
    tick(); adv = 0; valid = 1; op = SH; alu = 32'h2001; #1;
    chk("sh_mis_ades", ades, 1); chk("sh_mis_badv", badv, 32'h2001);
    chk("sh_mis_stall", stall, 0);
    tick(); #1;
    chk("sh_mis_req", req, 0);
    op = SW; alu = 32'h3002; #1;
    chk("sw_mis_ades", ades, 1); chk("sw_mis_badv", badv, 32'h3002);
    op = LW; alu = 32'h3000; #1;
    chk("lw_ades", ades, 0); chk("lw_stall", stall, 0);
    tick(); #1;
    chk("lw_req", req, 0);

    // flush in accept cycle
    op = SW; alu = 32'h3000; wd = 32'hDEAD_BEEF; flush = 1; #1;
    chk("flush_stall", stall, 0); chk("flush_ades", ades, 0);
    tick(); flush = 0; valid = 0; #1;
    chk("flush_req", req, 0);

    // SW: req held 3 cycles, flush ignored mid-REQ, data_ok 2 cycles after addr_ok
    tick(); valid = 1; op = SW; alu = 32'h3000; wd = 32'hDEAD_BEEF; #1;
    chk("sw_acc_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); flush = (i == 1); addr_ok = (i == 2); #1;
      chk("sw_req", req, 1); chk("sw_wdata", dwdata, 32'hDEAD_BEEF);
      chk("sw_strb", dstrb, 4'b1111); chk("sw_size", dsize, 2);
      chk("sw_addr", daddr, 32'h3000); chk("sw_stall", stall, 1);
    end
    tick(); flush = 0; addr_ok = 0; #1;
    chk("sw_wait_req", req, 0); chk("sw_wait_stall", stall, 1); chk("sw_wait_done", done, 0);
    tick(); data_ok = 1; #1;
    chk("sw_done", done, 1); chk("sw_dok_stall", stall, 0);
    tick(); data_ok = 0; valid = 0; adv = 1; #1;
    chk("sw_done_pulse", done, 0);

    // timeout: data_ok never arrives
    tick(); adv = 0; valid = 1; op = SB; alu = 32'h10; wd = 32'h5A; #1;
    chk("to_acc_stall", stall, 1);
    tick(); addr_ok = 1; #1;
    chk("to_wdata", dwdata, 32'h5A5A_5A5A); chk("to_strb", dstrb, 4'b0001);
    tick(); addr_ok = 0; #1;
    chk("to_cnt0_berr", berr, 0); chk("to_cnt0_stall", stall, 1);
    tick(); #1; chk("to_cnt1_berr", berr, 0);
    tick(); #1; chk("to_cnt2_berr", berr, 0); chk("to_cnt2_stall", stall, 1);
    tick(); #1;
    chk("to_berr", berr, 1); chk("to_stall", stall, 0); chk("to_done", done, 0);
    tick(); #1;
    chk("to_berr_pulse", berr, 0); chk("to_hold_stall", stall, 0); chk("to_hold_req", req, 0);
    tick(); valid = 0; adv = 1;

    // data_ok in the would-be timeout cycle takes priority
    tick(); adv = 0; valid = 1; op = SW; alu = 32'h40; wd = 32'h1;
    tick(); addr_ok = 1;
    tick(); addr_ok = 0;
    tick(); tick();
    tick(); data_ok = 1; #1;
    chk("prio_done", done, 1); chk("prio_berr", berr, 0); chk("prio_stall", stall, 0);
    tick(); data_ok = 0; valid = 0; adv = 1;

    // reset while in WAIT
    tick(); adv = 0; valid = 1; op = SW; alu = 32'h80; wd = 32'h55;
    tick(); addr_ok = 1;
    tick(); addr_ok = 0; valid = 0; #1;
    chk("wr_wait_stall", stall, 1);
    #2 rst = 1; #1;
    chk("mrst_req", req, 0);     chk("mrst_stall", stall, 0);
    chk("mrst_done", done, 0);   chk("mrst_berr", berr, 0);
    chk("mrst_wdata", dwdata, 0); chk("mrst_strb", dstrb, 0);
    chk("mrst_addr", daddr, 0);  chk("mrst_size", dsize, 0);
    tick(); rst = 0; #1;
    chk("mrst_idle_req", req, 0); chk("mrst_idle_stall", stall, 0);
    tick(); #1;
    chk("mrst_idle_req2", req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
